// File: rtl/lockin_plot_scheduler.sv
// Lock-in plot scheduler: decimates/averages the CORDIC stream to one value per plot column
// and aligns each 320-column sweep to a frame-swap tick. Define LOCKIN_SCHED_AVG_EN for boxcar averaging.
module lockin_plot_scheduler #(
    parameter int CORDIC_WIDTH = 42,
    parameter int PLOT_COLS    = 320,
    parameter int MAX_LOG2     = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [CORDIC_WIDTH-1:0] i_magnitude,
    input  logic [CORDIC_WIDTH-1:0] i_phase,
    input  logic                    i_swap_tick,
    input  logic                    i_run,
    input  logic                    i_single,
    input  logic [3:0]              i_decim_log2,
    output logic                    o_valid,
    output logic [CORDIC_WIDTH-1:0] o_magnitude,
    output logic [CORDIC_WIDTH-1:0] o_phase,
    output logic [8:0]              o_col,
    output logic                    o_sweep_done,
    output logic [1:0]              o_state
);
    localparam int AW = CORDIC_WIDTH + MAX_LOG2;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, HOLD = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic                    single_req_q, single_req_d;
    logic [3:0]              k_q, k_d;
    logic [MAX_LOG2-1:0]     cnt_q, cnt_d;
    logic [8:0]              col_q, col_d;
    logic                    valid_q, valid_d;
    logic                    done_q, done_d;
    logic [CORDIC_WIDTH-1:0] mag_q, mag_d;
    logic [CORDIC_WIDTH-1:0] phs_q, phs_d;
    logic [8:0]              col_out_q, col_out_d;

    logic                    acc_clr, acc_add;
    logic [3:0]              k_clamped;
    logic [MAX_LOG2-1:0]     last_cnt;
    logic [CORDIC_WIDTH-1:0] col_mag, col_phs;

    assign k_clamped = (i_decim_log2 > 4'(MAX_LOG2)) ? 4'(MAX_LOG2) : i_decim_log2;
    // N-1 as an all-ones mask of k bits
    assign last_cnt  = {MAX_LOG2{1'b1}} >> (4'(MAX_LOG2) - k_q);

`ifdef LOCKIN_SCHED_AVG_EN
    logic        [AW-1:0] acc_mag_q, acc_mag_d, sum_mag;
    logic signed [AW-1:0] acc_phs_q, acc_phs_d, sum_phs;

    assign sum_mag = acc_mag_q + AW'(i_magnitude);
    assign sum_phs = acc_phs_q + {{MAX_LOG2{i_phase[CORDIC_WIDTH-1]}}, i_phase};
    // Arithmetic shift on the signed sum gives the floor of the mean
    assign col_mag = CORDIC_WIDTH'(sum_mag >> k_q);
    assign col_phs = CORDIC_WIDTH'(sum_phs >>> k_q);

    always_comb begin
        acc_mag_d = acc_mag_q;
        acc_phs_d = acc_phs_q;
        if (acc_clr) begin
            acc_mag_d = '0;
            acc_phs_d = '0;
        end else if (acc_add) begin
            acc_mag_d = sum_mag;
            acc_phs_d = sum_phs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_mag_q <= '0;
            acc_phs_q <= '0;
        end else begin
            acc_mag_q <= acc_mag_d;
            acc_phs_q <= acc_phs_d;
        end
    end
`else
    assign col_mag = i_magnitude;
    assign col_phs = i_phase;
`endif

    always_comb begin
        state_d      = state_q;
        single_req_d = single_req_q | i_single;
        k_d          = k_q;
        cnt_d        = cnt_q;
        col_d        = col_q;
        valid_d      = 1'b0;
        done_d       = 1'b0;
        mag_d        = mag_q;
        phs_d        = phs_q;
        col_out_d    = col_out_q;
        acc_clr      = 1'b0;
        acc_add      = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_run || i_single) state_d = ARMED;
            end
            ARMED: begin
                if (!i_run && !single_req_q) begin
                    state_d = IDLE;
                end else if (i_swap_tick) begin
                    k_d     = k_clamped;
                    cnt_d   = '0;
                    col_d   = '0;
                    acc_clr = 1'b1;
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (!i_run && !single_req_q) begin
                    state_d = IDLE;
                end else if (i_valid) begin
                    if (cnt_q == last_cnt) begin
                        valid_d   = 1'b1;
                        mag_d     = col_mag;
                        phs_d     = col_phs;
                        col_out_d = col_q;
                        cnt_d     = '0;
                        acc_clr   = 1'b1;
                        if (col_q == 9'(PLOT_COLS - 1)) begin
                            done_d       = 1'b1;
                            state_d      = HOLD;
                            // The finished sweep consumes the request; only a new pulse re-arms
                            single_req_d = i_single;
                        end else begin
                            col_d = col_q + 9'd1;
                        end
                    end else begin
                        cnt_d   = cnt_q + MAX_LOG2'(1);
                        acc_add = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (i_swap_tick) begin
                    if (i_run || single_req_q || i_single) begin
                        state_d = ARMED;
                    end else begin
                        state_d      = IDLE;
                        single_req_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            single_req_q <= 1'b0;
            k_q          <= '0;
            cnt_q        <= '0;
            col_q        <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            mag_q        <= '0;
            phs_q        <= '0;
            col_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            single_req_q <= single_req_d;
            k_q          <= k_d;
            cnt_q        <= cnt_d;
            col_q        <= col_d;
            valid_q      <= valid_d;
            done_q       <= done_d;
            mag_q        <= mag_d;
            phs_q        <= phs_d;
            col_out_q    <= col_out_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_sweep_done = done_q;
    assign o_magnitude  = mag_q;
    assign o_phase      = phs_q;
    assign o_col        = col_out_q;
    assign o_state      = state_q;
endmodule
